// File: rtl/ahb_sram_subordinate_if.sv
// AHB-Lite bus bundle for one subordinate slot.
// The master side drives the address/data phase; the slave side answers.
interface ahb_sram_subordinate_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic [1:0]            HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE,
    output HSIZE, HBURST, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE,
    input  HSIZE, HBURST, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate over a word-organised SRAM.
// Programmable wait states, byte/half/word writes, two-cycle ERROR.
module ahb_sram_subordinate #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input logic HCLK,
  input logic HRESET,
  ahb_sram_subordinate_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [AW+1:0] addr_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic [3:0]    cnt;
  logic [3:0]    be;
  logic [AW-1:0] idx;
  logic          accept;
  logic          open;
  logic          take;
  logic          err;
  logic          unused;

  assign unused = ^bus.HBURST;
  assign idx    = addr_q[AW+1:2];

  // Address phase sampling and decode of illegal transfers
  always_comb begin
    accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    open   = (state == ST_IDLE) | (state == ST_DATA) |
             (state == ST_ERR2);
    take   = accept & open;
    err    = (|bus.HADDR[ADDR_WIDTH-1:AW+2]) |
             (bus.HSIZE > 3'd2) |
             ((bus.HSIZE == 3'd1) & bus.HADDR[0]) |
             ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'b00));
  end

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = ST_IDLE;
    unique case (state)
      ST_WAIT: state_nx = (cnt == 4'd0) ? ST_DATA : ST_WAIT;
      ST_ERR1: state_nx = ST_ERR2;
      default: begin
        if (take) begin
          if (err)                  state_nx = ST_ERR1;
          else if (WAIT_STATES > 0) state_nx = ST_WAIT;
          else                      state_nx = ST_DATA;
        end
      end
    endcase
  end

  // Bus response outputs, read data only in a read completion cycle
  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 2'b00;
    unique case (state)
      ST_WAIT: bus.HREADYOUT = 1'b0;
      ST_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 2'b01;
      end
      ST_ERR2: bus.HRESP = 2'b01;
      default: ;
    endcase
    bus.HRDATA = '0;
    if (state == ST_DATA && !write_q)
      bus.HRDATA = mem[idx];
  end

  // Address-phase capture and wait-state counter
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      cnt     <= 4'd0;
    end else if (take) begin
      addr_q  <= bus.HADDR[AW+1:0];
      write_q <= bus.HWRITE;
      size_q  <= bus.HSIZE;
      cnt     <= 4'(WAIT_STATES - 1);
    end else if (state == ST_WAIT) begin
      cnt     <= cnt - 4'd1;
    end
  end

  // Byte-lane enables, little-endian
  always_comb begin
    be = 4'b0000;
    unique case (1'b1)
      size_q == 3'd0: be = 4'b0001 << addr_q[1:0];
      size_q == 3'd1: be = addr_q[1] ? 4'b1100 : 4'b0011;
      default:        be = 4'b1111;
    endcase
  end

  // Write commits on the closing edge of the completion cycle
  always_ff @(posedge HCLK) begin
    if (state == ST_DATA && write_q) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
    end
  end
endmodule
